// File: rtl/alarm_sequencer.sv
// Alarm sequencer: sensor synchronise/debounce, arm/exit/entry/alarm FSM,
// siren blink generator and a small Avalon-MM register file.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// DISARMED    | idle, waiting for an arm write
// EXIT_DELAY  | armed by software, counting down before sensors are watched
// ARMED       | watching enabled sensors for a trip
// ENTRY_DELAY | trip seen, counting down to give the user time to disarm
// ALARM       | alarm latched, siren blinking until disarmed
module alarm_sequencer #(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int BLINK_TICKS    = 50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic [3:0]  sensor,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        siren,
  output logic        led_armed
);

  typedef enum logic [2:0] {
    S_DISARMED    = 3'd0,
    S_EXIT_DELAY  = 3'd1,
    S_ARMED       = 3'd2,
    S_ENTRY_DELAY = 3'd3,
    S_ALARM       = 3'd4
  } state_t;

  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_TICKS);
  localparam int BL_W = $clog2(BLINK_TICKS + 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_TICKS - 1);

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic [BL_W-1:0]   r_blink;
  logic              r_siren;
  logic              r_led;
  logic              r_alarm_flag;
  logic [1:0]        r_ctrl;
  logic [7:0]        r_delay;
  logic [3:0]        r_mask;
  logic [3:0]        r_sync1;
  logic [3:0]        r_sync2;
  logic [DB_W-1:0]   r_db [4];
  logic [15:0]       r_readdata;

  logic              w_wr;
  logic              w_clr_flag;
  logic              w_arm_wr;
  logic              w_disarm_wr;
  logic [3:0]        w_trip;
  logic              w_trip_any;
  logic              w_unused;

  assign w_wr        = chipselect && !write_n;
  assign w_clr_flag  = w_wr && (address == 3'd0);
  assign w_arm_wr    = w_wr && (address == 3'd1) && writedata[0];
  assign w_disarm_wr = w_wr && (address == 3'd1) && !writedata[0];
  assign w_unused    = ^writedata[15:8];

  always_comb begin
    w_trip = '0;
    for (int i = 0; i < 4; i++) w_trip[i] = (r_db[i] == DB_MAX);
  end

  assign w_trip_any = |(w_trip & r_mask);

  // Two-flop synchronizer on the raw sensor lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sensor;
      r_sync2 <= r_sync1;
    end
  end

  // Per-sensor debounce: count high ticks up to saturation, clear on a low tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) r_db[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (!r_sync2[i])            r_db[i] <= '0;
        else if (r_db[i] != DB_MAX) r_db[i] <= r_db[i] + 1'b1;
      end
    end
  end

  // Software-writable configuration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl  <= 2'b00;
      r_delay <= 8'd10;
      r_mask  <= 4'hF;
    end else if (w_wr) begin
      case (address)
        3'd1:    r_ctrl  <= writedata[1:0];
        3'd2:    r_delay <= writedata[7:0];
        3'd3:    r_mask  <= writedata[3:0];
        default: ;
      endcase
    end
  end

  // Sequencer FSM with registered siren/led outputs and sticky alarm flag.
  // Disarm has top priority; an alarm entry overrides a same-cycle flag clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_DISARMED;
      r_cnt        <= '0;
      r_blink      <= '0;
      r_siren      <= 1'b0;
      r_led        <= 1'b0;
      r_alarm_flag <= 1'b0;
    end else begin
      if (w_clr_flag) r_alarm_flag <= 1'b0;
      if (w_disarm_wr) begin
        r_state <= S_DISARMED;
        r_siren <= 1'b0;
        r_led   <= 1'b0;
      end else begin
        case (r_state)
          S_DISARMED: begin
            if (w_arm_wr) begin
              r_led <= 1'b1;
              if (r_delay == 8'd0) begin
                r_state <= S_ARMED;
              end else begin
                r_cnt   <= r_delay;
                r_state <= S_EXIT_DELAY;
              end
            end
          end
          S_EXIT_DELAY: begin
            if (tick) begin
              r_cnt <= r_cnt - 8'd1;
              if (r_cnt == 8'd1) r_state <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (w_trip_any) begin
              if (r_delay == 8'd0) begin
                r_state      <= S_ALARM;
                r_alarm_flag <= 1'b1;
                r_blink      <= '0;
                r_siren      <= 1'b1;
              end else begin
                r_cnt   <= r_delay;
                r_state <= S_ENTRY_DELAY;
              end
            end
          end
          S_ENTRY_DELAY: begin
            if (tick) begin
              r_cnt <= r_cnt - 8'd1;
              if (r_cnt == 8'd1) begin
                r_state      <= S_ALARM;
                r_alarm_flag <= 1'b1;
                r_blink      <= '0;
                r_siren      <= 1'b1;
              end
            end
          end
          S_ALARM: begin
            if (tick) begin
              if (r_blink == BL_LAST) begin
                r_blink <= '0;
                r_siren <= ~r_siren;
              end else begin
                r_blink <= r_blink + 1'b1;
              end
            end
          end
          default: begin
            r_state <= S_DISARMED;
            r_siren <= 1'b0;
            r_led   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Zero-wait-state read mux, registered every clock from the current address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      case (address)
        3'd0:    r_readdata <= {8'b0, w_trip, 1'b0, r_state};
        3'd1:    r_readdata <= {14'b0, r_ctrl};
        3'd2:    r_readdata <= {8'b0, r_delay};
        3'd3:    r_readdata <= {12'b0, r_mask};
        default: r_readdata <= '0;
      endcase
    end
  end

  assign readdata  = r_readdata;
  assign irq       = r_alarm_flag & r_ctrl[1];
  assign siren     = r_siren;
  assign led_armed = r_led;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: register reads go through an
// expectation queue; discrete outputs are compared directly.
module tb_alarm_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  sensor = 4'h0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'h0;
  logic [15:0] readdata;
  logic        irq, siren, led_armed;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp_v;

  alarm_sequencer #(.DEBOUNCE_TICKS(3), .BLINK_TICKS(50)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .sensor(sensor),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq),
    .siren(siren), .led_armed(led_armed)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1; writedata = 16'h0;
  endtask

  // Queue the expected word, then present the address for one clock.
  task automatic rd(input logic [2:0] a, input logic [15:0] e);
    exp_q.push_back(e);
    address = a;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    checks++; if (readdata !== 16'h0 || irq !== 1'b0 || siren !== 1'b0 || led_armed !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got rd=%h irq=%b siren=%b led=%b want all 0", readdata, irq, siren, led_armed); end
    reset_n = 1'b1;
    step();
    rd(3'd2, 16'h000A); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL reset_delay got=%h want=%h", readdata, exp_v); end
    rd(3'd3, 16'h000F); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL reset_mask got=%h want=%h", readdata, exp_v); end
    rd(3'd0, 16'h0000); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL reset_status got=%h want=%h", readdata, exp_v); end
  endtask

  task automatic test_exit_delay();
    bus_write(3'd2, 16'd3);
    bus_write(3'd1, 16'h0001);
    rd(3'd0, 16'h0001); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL exit_state got=%h want=%h", readdata, exp_v); end
    checks++; if (led_armed !== 1'b1) begin failures++; $display("FAIL exit_led got=%b want=1", led_armed); end
    ticks(2);
    rd(3'd0, 16'h0001); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL exit_two_ticks got=%h want=%h", readdata, exp_v); end
    ticks(1);
    rd(3'd0, 16'h0002); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL exit_armed got=%h want=%h", readdata, exp_v); end
    checks++; if (led_armed !== 1'b1 || siren !== 1'b0) begin failures++; $display("FAIL armed_led got led=%b siren=%b want 1/0", led_armed, siren); end
  endtask

  task automatic test_mask_debounce();
    bus_write(3'd3, 16'h0003);
    sensor = 4'b0100; step(); step();
    ticks(3);
    rd(3'd0, 16'h0042); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL masked_trip got=%h want=%h", readdata, exp_v); end
    sensor = 4'b0000; step(); step(); ticks(1);
    sensor = 4'b0001; step(); step(); ticks(2);
    rd(3'd0, 16'h0002); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL short_pulse_high got=%h want=%h", readdata, exp_v); end
    sensor = 4'b0000; step(); step(); ticks(1);
    rd(3'd0, 16'h0002); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL short_pulse_low got=%h want=%h", readdata, exp_v); end
  endtask

  task automatic test_entry_alarm();
    bus_write(3'd3, 16'h0001);
    sensor = 4'b0001; step(); step();
    ticks(3);
    rd(3'd0, 16'h0013); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL entry_state got=%h want=%h", readdata, exp_v); end
    ticks(3);
    rd(3'd0, 16'h0014); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL alarm_state got=%h want=%h", readdata, exp_v); end
    checks++; if (siren !== 1'b1 || irq !== 1'b0) begin failures++; $display("FAIL alarm_outputs got siren=%b irq=%b want 1/0", siren, irq); end
    bus_write(3'd1, 16'h0003);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_enable got=%b want=1", irq); end
    rd(3'd0, 16'h0014); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL arm_in_alarm got=%h want=%h", readdata, exp_v); end
    sensor = 4'b0000;
    ticks(49);
    checks++; if (siren !== 1'b1) begin failures++; $display("FAIL blink_49 got=%b want=1", siren); end
    ticks(1);
    checks++; if (siren !== 1'b0) begin failures++; $display("FAIL blink_50 got=%b want=0", siren); end
    ticks(50);
    checks++; if (siren !== 1'b1) begin failures++; $display("FAIL blink_100 got=%b want=1", siren); end
  endtask

  task automatic test_disarm();
    bus_write(3'd1, 16'h0002);
    checks++; if (siren !== 1'b0 || led_armed !== 1'b0 || irq !== 1'b1) begin
      failures++; $display("FAIL disarm_outputs got siren=%b led=%b irq=%b want 0/0/1", siren, led_armed, irq); end
    rd(3'd0, 16'h0000); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL disarm_state got=%h want=%h", readdata, exp_v); end
    bus_write(3'd0, 16'h0000);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL flag_clear got=%b want=0", irq); end
  endtask

  task automatic test_zero_delay();
    bus_write(3'd2, 16'h0000);
    bus_write(3'd1, 16'h0003);
    rd(3'd0, 16'h0002); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL zero_delay_arm got=%h want=%h", readdata, exp_v); end
    sensor = 4'b0001; step(); step();
    ticks(3);
    rd(3'd0, 16'h0014); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL zero_delay_alarm got=%h want=%h", readdata, exp_v); end
    checks++; if (siren !== 1'b1 || irq !== 1'b1) begin failures++; $display("FAIL zero_delay_outputs got siren=%b irq=%b want 1/1", siren, irq); end
    sensor = 4'b0000;
    reset_n = 1'b0;
    #2;
    checks++; if (readdata !== 16'h0 || irq !== 1'b0 || siren !== 1'b0 || led_armed !== 1'b0) begin
      failures++; $display("FAIL midalarm_reset got rd=%h irq=%b siren=%b led=%b want all 0", readdata, irq, siren, led_armed); end
    step();
    reset_n = 1'b1;
    step();
    rd(3'd2, 16'h000A); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL reset_delay_again got=%h want=%h", readdata, exp_v); end
    rd(3'd0, 16'h0000); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL reset_status_again got=%h want=%h", readdata, exp_v); end
  endtask

  task automatic test_races();
    bus_write(3'd2, 16'd1);
    bus_write(3'd1, 16'h0001);
    address = 3'd1; writedata = 16'h0000; chipselect = 1'b1; write_n = 1'b0; tick = 1'b1;
    step();
    chipselect = 1'b0; write_n = 1'b1; tick = 1'b0;
    rd(3'd0, 16'h0000); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL disarm_vs_expiry got=%h want=%h", readdata, exp_v); end
    bus_write(3'd2, 16'd2);
    bus_write(3'd1, 16'h0001);
    bus_write(3'd2, 16'd5);
    ticks(2);
    rd(3'd0, 16'h0002); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL delay_write_midcount got=%h want=%h", readdata, exp_v); end
    bus_write(3'd2, 16'd0);
    bus_write(3'd1, 16'h0003);
    sensor = 4'b0001; step(); step();
    ticks(2);
    tick = 1'b1; step();
    tick = 1'b0; address = 3'd0; writedata = 16'h0; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL set_beats_clear got=%b want=1", irq); end
    rd(3'd0, 16'h0014); exp_v = exp_q.pop_front();
    checks++; if (readdata !== exp_v) begin failures++; $display("FAIL race_alarm_state got=%h want=%h", readdata, exp_v); end
    sensor = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_exit_delay();
    test_mask_debounce();
    test_entry_alarm();
    test_disarm();
    test_zero_delay();
    test_races();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter DEBOUNCE_TICKS, default 3: consecutive active tick samples needed to declare a sensor tripped.
REQ-002 Parameter BLINK_TICKS, default 50: ticks per half-period of the siren blink output.
REQ-003 clk  input  1  system clock; all logic rising-edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 tick  input  1  one-clk pulse from the upstream periodic timer; timebase for all delays.
REQ-006 sensor  input  4  raw asynchronous door/motion sensor lines, active-high.
REQ-007 address  input  3  Avalon-MM slave word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  16  write data.
REQ-011 readdata  output  16  registered read data.
REQ-012 irq  output  1  level interrupt: alarm_flag AND irq_en.
REQ-013 siren  output  1  blinking alarm drive.
REQ-014 led_armed  output  1  high in EXIT_DELAY, ARMED, ENTRY_DELAY, ALARM.

Function
REQ-015 Write strobe = chipselect && !write_n; reads have zero wait states; readdata updates every clk with the mux of the current address, one-clk latency.
REQ-016 Register map: addr0 STATUS R: {8'b0, sensor_trip[3:0], 1'b0, state[2:0]}; write any value clears alarm_flag. addr1 CONTROL R/W bits[1:0] = {irq_en, arm}. addr2 DELAY R/W bits[7:0], delay in ticks. addr3 MASK R/W bits[3:0], 1 = sensor enabled. Other addresses read 0, writes ignored.
REQ-017 Sensors pass a 2-flop synchronizer; debounce counter per sensor increments on tick while synced input high, clears on tick while low, saturates at DEBOUNCE_TICKS; sensor_trip[i] = counter == DEBOUNCE_TICKS.
REQ-018 trip_any = |(sensor_trip & MASK).
REQ-019 States/encoding: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4.
REQ-020 DISARMED: CONTROL write with arm=1 loads delay counter from DELAY, goes EXIT_DELAY; if DELAY=0 goes directly ARMED.
REQ-021 EXIT_DELAY: counter decrements on tick; reaching 0 goes ARMED; trips ignored.
REQ-022 ARMED: trip_any loads counter from DELAY, goes ENTRY_DELAY; DELAY=0 goes directly ALARM.
REQ-023 ENTRY_DELAY: decrement on tick; reaching 0 goes ALARM.
REQ-024 Entering ALARM sets alarm_flag (sticky) and starts blink counter at 0 with siren=1; siren toggles every BLINK_TICKS ticks.
REQ-025 CONTROL write with arm=0 from any state goes DISARMED next clk, siren=0; alarm_flag unchanged.
REQ-026 CONTROL arm=1 write while not DISARMED: no state change.
REQ-027 Simultaneous STATUS write and ALARM entry in same clk: set wins, alarm_flag=1.
REQ-028 Simultaneous disarm write and delay expiry/trip: disarm wins.
REQ-029 DELAY writes during a countdown do not affect the running count; used at next load.
REQ-030 siren=0 in every state except ALARM.

Reset
REQ-031 On reset_n low: state=DISARMED, CONTROL=0, DELAY=8'd10, MASK=4'hF, debounce counters/synchronizers=0, alarm_flag=0, readdata=0, irq=0, siren=0, led_armed=0; takes effect immediately, mid-countdown or mid-alarm.

Verification
REQ-032 Write DELAY=3, CONTROL=1 -> STATUS state 1, after 3 ticks state 2, led_armed=1.
REQ-033 ARMED, sensor[0] high 3 ticks (MASK=1) -> state 3; 3 further ticks -> state 4, siren=1, irq=0 until CONTROL=3 then irq=1.
REQ-034 sensor[2] high with MASK=4'h3 -> sensor_trip=4'b0100 read, state stays 2; sensor high 2 ticks then low -> no trip.
REQ-035 In ALARM, BLINK_TICKS=50 -> siren toggles every 50 ticks; CONTROL=0 -> state 0, siren=0, irq stays 1 until STATUS write -> irq=0.
REQ-036 DELAY=0 arm -> ARMED next clk; trip -> ALARM directly; reset_n pulse mid-ALARM -> all outputs 0, DELAY reads 10.
